card_request_initiator: RTL

CARD_REQUEST_INITIATOR -- requirements
Module: card_request_initiator

---
 rtl/rng_pkg.sv | 7 +
 rtl/card_request_initiator_if.sv | 21 ++
 rtl/req_timeout_counter.sv | 24 ++
 rtl/card_request_initiator.sv | 72 +++++++
 4 files changed

// File: rtl/rng_pkg.sv
// rng_pkg: state encodings and card/deck defaults shared with the control path
package rng_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RELEASE = 2'd2} state_e;
  localparam int CARD_W_DEF = 6;
  localparam int DECK_SIZE_DEF = 52;
  localparam int TIMEOUT_CYCLES_DEF = 16;
endpackage

// File: rtl/card_request_initiator_if.sv
// card_request_initiator_if: user request, control-path handshake and card result signals
interface card_request_initiator_if #(parameter int CARD_W = 6);
  logic start_i;
  logic send_state_i;
  logic [CARD_W-1:0] card_data_i;
  logic req_card_state_o;
  logic [CARD_W-1:0] card_o;
  logic card_valid_o;
  logic timeout_o;
  logic busy_o;
  logic [CARD_W-1:0] dealt_cnt_o;
  logic deck_done_o;
  modport master (
    input start_i, send_state_i, card_data_i,
    output req_card_state_o, card_o, card_valid_o, timeout_o, busy_o, dealt_cnt_o, deck_done_o
  );
  modport slave (
    output start_i, send_state_i, card_data_i,
    input req_card_state_o, card_o, card_valid_o, timeout_o, busy_o, dealt_cnt_o, deck_done_o
  );
endinterface

// File: rtl/req_timeout_counter.sv
// req_timeout_counter: counts waiting cycles and flags the last one before abort
module req_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  // Clear wins over enable; hold at the terminal value until cleared
  always_comb begin
    cnt_d = clr ? '0 : (en && !tc) ? cnt_q + 1'b1 : cnt_q;
  end
  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign tc = (cnt_q == LAST);
endmodule

// File: rtl/card_request_initiator.sv
// card_request_initiator: requests one card from the control path, captures and range-reduces it
module card_request_initiator
  import rng_pkg::*;
#(
  parameter int CARD_W = CARD_W_DEF,
  parameter int DECK_SIZE = DECK_SIZE_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic clk_rq_i,
  input logic rst_rq_i,
  card_request_initiator_if.master bus
);
  localparam logic [CARD_W-1:0] DECK_V = CARD_W'(DECK_SIZE);
  localparam logic [CARD_W-1:0] LAST_V = CARD_W'(DECK_SIZE - 1);
  state_e state_q, state_d;
  logic req_q, req_d, busy_q, busy_d;
  logic [CARD_W-1:0] card_q, card_d, dealt_q, dealt_d, reduced;
  logic valid_q, valid_d, timeout_q, timeout_d, done_q, done_d;
  logic capture, tc, tmr_clr, tmr_en;
  req_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_tmr (
    .clk(clk_rq_i), .rst_n(rst_rq_i), .clr(tmr_clr), .en(tmr_en), .tc(tc)
  );
  // State and output registers; reset drops the request asynchronously
  always_ff @(posedge clk_rq_i or negedge rst_rq_i) begin
    if (!rst_rq_i) begin
      state_q <= IDLE;
      req_q <= 1'b0;
      busy_q <= 1'b0;
      card_q <= '0;
      valid_q <= 1'b0;
      timeout_q <= 1'b0;
      dealt_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      busy_q <= busy_d;
      card_q <= card_d;
      valid_q <= valid_d;
      timeout_q <= timeout_d;
      dealt_q <= dealt_d;
      done_q <= done_d;
    end
  end
  // Next state: capture and timeout both leave WAIT; RELEASE waits for send to fall
  always_comb begin
    state_d = (state_q == IDLE && bus.start_i) ? WAIT :
              (state_q == WAIT && (bus.send_state_i || tc)) ? RELEASE :
              (state_q == RELEASE && !bus.send_state_i) ? IDLE : state_q;
  end
  // Output decode; capture takes priority over a simultaneous timeout
  always_comb begin
    capture = (state_q == WAIT) && bus.send_state_i;
    reduced = (int'(bus.card_data_i) < DECK_SIZE) ? bus.card_data_i : bus.card_data_i - DECK_V;
    tmr_clr = (state_q == IDLE) && bus.start_i;
    tmr_en = (state_q == WAIT) && !bus.send_state_i;
    req_d = (state_d == WAIT);
    busy_d = (state_d != IDLE);
    valid_d = capture;
    timeout_d = tmr_en && tc;
    card_d = capture ? reduced : card_q;
    dealt_d = capture ? ((dealt_q == LAST_V) ? '0 : dealt_q + 1'b1) : dealt_q;
    done_d = capture && (dealt_q == LAST_V);
  end
  assign bus.req_card_state_o = req_q;
  assign bus.busy_o = busy_q;
  assign bus.card_o = card_q;
  assign bus.card_valid_o = valid_q;
  assign bus.timeout_o = timeout_q;
  assign bus.dealt_cnt_o = dealt_q;
  assign bus.deck_done_o = done_q;
endmodule
